// File: rtl/div_seq_if.sv
// Divider stall interface between the execute stage (master) and div_seq (slave).
interface div_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic               start;
    logic               signed_div;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               annul;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] result;

    modport master (
        output start, signed_div, a, b, annul,
        input  busy, done, result
    );

    modport slave (
        input  start, signed_div, a, b, annul,
        output busy, done, result
    );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) for the MIPS execute stage.
// result = {remainder, quotient}; busy feeds the hazard unit stall logic.
// Optional macro DIV_EARLY_ZERO_EN: a zero divisor skips the iterations and
// reaches DONE one cycle after start.
module div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input logic      clk,
    input logic      resetn,
    div_seq_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} stateE;

    stateE              state;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   dvsr;
    logic [WIDTH-1:0]   aRaw;
    logic               negQ;
    logic               negR;
    logic               divZero;
    logic [CntW-1:0]    cnt;
    logic               busyR;
    logic               doneR;
    logic [2*WIDTH-1:0] resultR;

    logic [WIDTH-1:0]   aMag;
    logic [WIDTH-1:0]   bMag;
    logic               bIsZero;
    logic [WIDTH:0]     remWide;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   stepRem;
    logic [WIDTH-1:0]   stepQuo;
    logic [WIDTH-1:0]   fixRem;
    logic [WIDTH-1:0]   fixQuo;
    logic [2*WIDTH-1:0] finalRes;

    assign bus.busy   = busyR;
    assign bus.done   = doneR;
    assign bus.result = resultR;

    // Operand magnitudes; the most negative value maps to 2^(W-1) unsigned.
    always_comb begin
        aMag    = bus.a;
        bMag    = bus.b;
        bIsZero = (bus.b == '0);
        if (bus.signed_div && bus.a[WIDTH-1]) aMag = ~bus.a + WIDTH'(1);
        if (bus.signed_div && bus.b[WIDTH-1]) bMag = ~bus.b + WIDTH'(1);
    end

    // One restoring step: shift {rem,quo} left, trial-subtract, keep if non-negative.
    always_comb begin
        remWide = {rem, quo[WIDTH-1]};
        trial   = remWide - {1'b0, dvsr};
        if (!trial[WIDTH]) begin
            stepRem = trial[WIDTH-1:0];
            stepQuo = {quo[WIDTH-2:0], 1'b1};
        end else begin
            stepRem = remWide[WIDTH-1:0];
            stepQuo = {quo[WIDTH-2:0], 1'b0};
        end
    end

    // Sign fix-up of the final step; a zero divisor bypasses it with the raw dividend.
    always_comb begin
        fixRem = negR ? (~stepRem + WIDTH'(1)) : stepRem;
        fixQuo = negQ ? (~stepQuo + WIDTH'(1)) : stepQuo;
        if (divZero) finalRes = {aRaw, {WIDTH{1'b1}}};
        else         finalRes = {fixRem, fixQuo};
    end

    // Control FSM with registered busy/done/result.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= StIdle;
            rem     <= '0;
            quo     <= '0;
            dvsr    <= '0;
            aRaw    <= '0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
            divZero <= 1'b0;
            cnt     <= '0;
            busyR   <= 1'b0;
            doneR   <= 1'b0;
            resultR <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    // annul beats a coincident start
                    if (bus.start && !bus.annul) begin
                        aRaw    <= bus.a;
                        negQ    <= bus.signed_div && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        negR    <= bus.signed_div && bus.a[WIDTH-1];
                        divZero <= bIsZero;
                        rem     <= '0;
                        quo     <= aMag;
                        dvsr    <= bMag;
                        cnt     <= CntW'(WIDTH);
`ifdef DIV_EARLY_ZERO_EN
                        if (bIsZero) begin
                            state   <= StDone;
                            doneR   <= 1'b1;
                            resultR <= {bus.a, {WIDTH{1'b1}}};
                        end else begin
                            state <= StCalc;
                            busyR <= 1'b1;
                        end
`else
                        state <= StCalc;
                        busyR <= 1'b1;
`endif
                    end
                end
                StCalc: begin
                    if (bus.annul) begin
                        state <= StIdle;
                        busyR <= 1'b0;
                    end else begin
                        rem <= stepRem;
                        quo <= stepQuo;
                        cnt <= cnt - CntW'(1);
                        if (cnt == CntW'(1)) begin
                            state   <= StDone;
                            busyR   <= 1'b0;
                            doneR   <= 1'b1;
                            resultR <= finalRes;
                        end
                    end
                end
                StDone: begin
                    doneR <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_div_seq;
    logic clk;
    logic resetn;
    int   total;
    int   passed;
    logic [63:0] lastExp;

    div_seq_if #(.WIDTH(32)) bus ();

    div_seq #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain signed/unsigned division with the zero-divisor rule.
    function automatic logic [63:0] refDiv(input logic sd, input logic [31:0] av,
                                           input logic [31:0] bv);
        longint sa, sb, sq, sr;
        logic [31:0] q, r;
        if (bv == 32'd0) return {av, 32'hFFFF_FFFF};
        if (sd) begin
            sa = longint'($signed(av));
            sb = longint'($signed(bv));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[31:0];
            r  = sr[31:0];
        end else begin
            q = av / bv;
            r = av % bv;
        end
        return {r, q};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Issue one divide and follow it to done; optionally pulse a stray start at cycle ignAt.
    task automatic runDiv(input string tag, input logic sd, input logic [31:0] av,
                          input logic [31:0] bv, input int ignAt);
        logic [63:0] exp;
        int          expLat;
        int          lat;
        int          busyCnt;
        logic        busyAtDone;
        exp = refDiv(sd, av, bv);
`ifdef DIV_EARLY_ZERO_EN
        expLat = (bv == 32'd0) ? 1 : 33;
`else
        expLat = 33;
`endif
        bus.start      = 1'b1;
        bus.signed_div = sd;
        bus.a          = av;
        bus.b          = bv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        lat        = 0;
        busyCnt    = 0;
        busyAtDone = 1'bx;
        for (int n = 1; n <= 100 && lat == 0; n++) begin
            @(negedge clk);
            if (bus.done) begin
                lat        = n;
                busyAtDone = bus.busy;
            end else if (bus.busy) begin
                busyCnt++;
            end
            if (n == ignAt) begin
                bus.start = 1'b1;
                bus.a     = 32'd50;
                bus.b     = 32'd5;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(expLat));
        check({tag, " result"}, bus.result, exp);
        check({tag, " busyCycles"}, 64'(busyCnt), 64'(expLat - 1));
        check({tag, " busyAtDone"}, 64'(busyAtDone), 64'd0);
        lastExp = exp;
        @(negedge clk);
        check({tag, " donePulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int          seen;
        logic        sd;
        logic [31:0] av, bv;
        total   = 0;
        passed  = 0;
        lastExp = 64'd0;
        resetn         = 1'b0;
        bus.start      = 1'b0;
        bus.signed_div = 1'b0;
        bus.a          = 32'd0;
        bus.b          = 32'd0;
        bus.annul      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset result", bus.result, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Directed cases
        runDiv("udiv 100/7", 1'b0, 32'd100, 32'd7, 0);
        check("udiv 100/7 const", lastExp, {32'd2, 32'd14});
        runDiv("sdiv -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        check("sdiv -7/2 const", lastExp, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        runDiv("sdiv 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        runDiv("sdiv ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("sdiv ovf const", lastExp, {32'd0, 32'h8000_0000});
        runDiv("udiv ovfops", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        runDiv("udiv by0", 1'b0, 32'h1234, 32'd0, 0);
        runDiv("sdiv by0 neg", 1'b1, 32'hFFFF_FF00, 32'd0, 0);
        runDiv("ignored start", 1'b0, 32'd100, 32'd7, 5);

        // Nothing queued from the stray start
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy || bus.done) seen++;
        end
        check("no queued start", 64'(seen), 64'd0);

        // annul and start together in IDLE: start dropped
        bus.start = 1'b1;
        bus.annul = 1'b1;
        bus.a     = 32'd77;
        bus.b     = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.annul = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy || bus.done) seen++;
        end
        check("annul+start idle", 64'(seen), 64'd0);
        check("annul+start result", bus.result, lastExp);

        // annul mid-calculation
        bus.start      = 1'b1;
        bus.signed_div = 1'b0;
        bus.a          = 32'd100;
        bus.b          = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int n = 1; n <= 10; n++) @(negedge clk);
        check("annul busy before", 64'(bus.busy), 64'd1);
        bus.annul = 1'b1;
        @(negedge clk);
        bus.annul = 1'b0;
        check("annul busy after", 64'(bus.busy), 64'd0);
        check("annul result held", bus.result, lastExp);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        check("annul no done", 64'(seen), 64'd0);
        runDiv("after annul 9/3", 1'b0, 32'd9, 32'd3, 0);
        check("after annul const", lastExp, {32'd0, 32'd3});

        // Reset mid-operation, with an ignored start at cycle 5
        bus.start = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            bus.start = (n == 5);
        end
        bus.start = 1'b0;
        resetn = 1'b0;
        #1;
        check("midreset busy", 64'(bus.busy), 64'd0);
        check("midreset done", 64'(bus.done), 64'd0);
        check("midreset result", bus.result, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy || bus.done) seen++;
        end
        check("post reset idle", 64'(seen), 64'd0);
        runDiv("post reset 9/3", 1'b0, 32'd9, 32'd3, 0);

        // Random operands
        for (int i = 0; i < 24; i++) begin
            sd = 1'($urandom_range(0, 1));
            av = $urandom;
            case ($urandom_range(0, 4))
                0:       bv = $urandom;
                1:       bv = 32'($urandom_range(1, 15));
                2:       bv = 32'd0 - 32'($urandom_range(1, 15));
                3:       bv = $urandom >> $urandom_range(0, 31);
                default: bv = (i % 8 == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
            endcase
            runDiv($sformatf("rand%0d", i), sd, av, bv, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle radix-2 restoring divider for the MIPS execute stage, implementing DIV and DIVU.
- It is the producer side of the divider stall interface: the execute stage raises start together with the divide-instruction flag, and this block drives busy, which the hazard unit ORs into stallD/stallF/flushE.
- Result is {remainder, quotient}, destined for HI and LO.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH; iteration counter is clog2(WIDTH)+1 bits.

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  request a divide; sampled only in IDLE
signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
a  in  WIDTH  dividend; sampled with start
b  in  WIDTH  divisor; sampled with start
annul  in  1  cancel an in-flight divide (exception/flush)
busy  out  1  divide in progress; feeds hazard unit divbusyE
done  out  1  one-cycle pulse, result valid
result  out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; busy=0, done=0, result=0; internal registers cleared. Reset mid-operation aborts with no done pulse.
- States: IDLE, CALC, DONE.
- IDLE: start=1 at edge T latches a, b, signed_div and the sign flags; converts operands to magnitudes when signed_div=1; loads counter=WIDTH; moves to CALC. start=0 stays in IDLE.
- CALC: busy=1 from T+1.
  - One restoring step per cycle: shift {rem,quo} left by 1 bit; trial-subtract divisor magnitude (WIDTH+1 bits); on non-negative, keep the difference and set quotient LSB=1.
  - After WIDTH iterations (cycles T+1..T+WIDTH), go to DONE.
- DONE (cycle T+WIDTH+1): busy=0, done=1; result registered with sign fix-up.
  - Quotient is negated if sign(a) != sign(b).
  - Remainder takes sign(a).
  - Next state is always IDLE.
- Total latency: done asserted WIDTH+1 cycles after the start edge (33 for WIDTH=32).
- result holds its value until the next DONE; it is not cleared by start or annul.
- start while busy=1 or in DONE is ignored. No queueing.
- annul=1 in CALC: next state IDLE; busy=0 next cycle; no done pulse; result unchanged.
- annul in IDLE or DONE has no effect; done still pulses if already in DONE.
- annul and start together in IDLE: annul wins, the start is dropped.
- Divide by zero (b=0), both modes: quotient=all ones, remainder=a unmodified (raw dividend). Sign fix-up is bypassed. Takes normal latency.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF): quotient=0x80000000, remainder=0 (wraps, no trap).
- Arithmetic wraps modulo 2^WIDTH. Magnitude of the most negative number is 2^(W-1) as unsigned.

Optional Feature:
- DIV_EARLY_ZERO_EN defined: b=0 detected in IDLE at the start edge goes directly to DONE.
  - done at T+1, busy never asserted.
  - Result as specified for divide by zero.
- Not defined: divide by zero runs the full WIDTH iterations.

Test Plan:
- Unsigned: start, signed_div=0, a=100, b=7 -> busy high cycles 1..32, done at cycle 33, result={32'd2, 32'd14}, busy=0 in the done cycle.
- Signed: a=0xFFFFFFF9 (-7), b=2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Also a=7, b=0xFFFFFFFE -> quotient=0xFFFFFFFD, remainder=1.
- Overflow/mode: a=0x80000000, b=0xFFFFFFFF signed -> q=0x80000000, r=0. Same operands unsigned -> q=0, r=0x80000000.
- Divide by zero: a=0x1234, b=0 -> q=0xFFFFFFFF, r=0x1234. done at cycle 33 without DIV_EARLY_ZERO_EN, at cycle 1 with it.
- Annul/restart: start 100/7, annul at cycle 10 -> busy=0 at 11, no done, result unchanged. New start 9/3 at 12 -> done at 45, result={0, 3}.
- Reset/ignored start: start at cycle 0, pulse start again at 5 (ignored). Drop resetn at 20 -> busy/done/result=0 immediately. After release, IDLE and a new start works.
